// File: rtl/result_collector.sv
// Gathers one prediction per core as each core's done rises and replays them
// downstream as a valid/ready stream in strict core order 0..N-1.
module result_collector #(
    parameter int N           = 4,
    parameter int output_size = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 batch_start,
    input  logic [N-1:0]                         core_done,
    input  logic [N*output_size-1:0]             core_value,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [output_size-1:0]               out_data,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_core_id,
    output logic                                 busy,
    output logic                                 batch_done,
    output logic                                 dup_err
);

    localparam int ID_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE
    } state_t;

    state_t                  state;
    logic [N-1:0]            prev_done;
    logic [N-1:0]            captured;
    logic [N-1:0]            cap_ev;
    logic [ID_W-1:0]         ptr;
    logic [ID_W-1:0]         ptr_inc;
    logic                    ptr_last;
    logic [output_size-1:0]  slot [N];

    // Rising edges of the done levels; a level held high never re-triggers.
    assign cap_ev   = core_done & ~prev_done;
    assign ptr_inc  = ptr + ID_W'(1);
    assign ptr_last = (ptr == ID_W'(N - 1));

    // Capture stage: slot storage is pure data and carries no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (state == S_COLLECT && cap_ev[i] && !captured[i]) begin
                slot[i] <= core_value[i*output_size +: output_size];
            end
        end
    end

    // Emit stage: the FSM and every registered output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            prev_done   <= '0;
            captured    <= '0;
            ptr         <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_core_id <= '0;
            busy        <= 1'b0;
            batch_done  <= 1'b0;
            dup_err     <= 1'b0;
        end else begin
            prev_done <= core_done;
            case (state)
                S_IDLE, S_DONE: begin
                    if (batch_start) begin
                        state       <= S_COLLECT;
                        captured    <= '0;
                        ptr         <= '0;
                        out_valid   <= 1'b0;
                        out_core_id <= '0;
                        busy        <= 1'b1;
                        batch_done  <= 1'b0;
                        dup_err     <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    captured <= captured | cap_ev;
                    if (|(cap_ev & captured)) begin
                        dup_err <= 1'b1;
                    end
                    if (out_valid && out_ready) begin
                        if (ptr_last) begin
                            state      <= S_DONE;
                            out_valid  <= 1'b0;
                            busy       <= 1'b0;
                            batch_done <= 1'b1;
                        end else begin
                            // Next slot may already be waiting: present it straight away.
                            ptr         <= ptr_inc;
                            out_valid   <= captured[ptr_inc];
                            out_data    <= slot[ptr_inc];
                            out_core_id <= ptr_inc;
                        end
                    end else if (!out_valid) begin
                        out_valid   <= captured[ptr];
                        out_data    <= slot[ptr];
                        out_core_id <= ptr;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector: expected beats are queued in core
// order per batch and matched against every accepted output beat.
module tb_result_collector;

    localparam int N    = 4;
    localparam int W    = 32;
    localparam int ID_W = 2;

    logic                 clk;
    logic                 rst;
    logic                 batch_start;
    logic [N-1:0]         core_done;
    logic [N*W-1:0]       core_value;
    logic                 out_valid;
    logic                 out_ready;
    logic [W-1:0]         out_data;
    logic [ID_W-1:0]      out_core_id;
    logic                 busy;
    logic                 batch_done;
    logic                 dup_err;

    logic [ID_W+W-1:0]    sb_q [$];
    int                   n_cmp;
    int                   n_err;
    int                   cyc;

    result_collector #(.N(N), .output_size(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .batch_start (batch_start),
        .core_done   (core_done),
        .core_value  (core_value),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_core_id (out_core_id),
        .busy        (busy),
        .batch_done  (batch_done),
        .dup_err     (dup_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accepted beats are compared at the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            check_eq("beat_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                logic [ID_W+W-1:0] e;
                e = sb_q.pop_front();
                check_eq("beat_id", 64'(out_core_id), 64'(e[ID_W+W-1:W]));
                check_eq("beat_data", 64'(out_data), 64'(e[W-1:0]));
            end
        end
    end

    task automatic push_exp(input int id, input logic [W-1:0] v);
        sb_q.push_back({ID_W'(id), v});
    endtask

    task automatic start_batch();
        @(posedge clk); #1 batch_start = 1'b1;
        @(posedge clk); #1 batch_start = 1'b0;
    endtask

    task automatic raise(input int i, input logic [W-1:0] v);
        @(posedge clk); #1;
        core_value[i*W +: W] = v;
        core_done[i]         = 1'b1;
    endtask

    task automatic drop(input int i);
        @(posedge clk); #1 core_done[i] = 1'b0;
    endtask

    task automatic drop_all();
        @(posedge clk); #1 core_done = '0;
    endtask

    task automatic drain(input int budget, output int cycles);
        cycles = 0;
        while (sb_q.size() != 0 && cycles < budget) begin
            @(posedge clk); #2;
            cycles++;
        end
        check_eq("drain_complete", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_valid"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_data"}, 64'(out_data), 64'd0);
        check_eq({tag, "_id"}, 64'(out_core_id), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_done"}, 64'(batch_done), 64'd0);
        check_eq({tag, "_dup"}, 64'(dup_err), 64'd0);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b0;
        batch_start = 1'b0;
        core_done   = '0;
        core_value  = '0;
        out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_idle_outputs("reset");
        rst = 1'b1;

        // In-order completion, one core per cycle.
        out_ready = 1'b1;
        start_batch();
        check_eq("t1_busy", 64'(busy), 64'd1);
        for (int i = 0; i < N; i++) push_exp(i, 32'h100 + i);
        for (int i = 0; i < N; i++) raise(i, 32'h100 + i);
        drop_all();
        drain(40, cyc);
        check_eq("t1_batch_done", 64'(batch_done), 64'd1);
        check_eq("t1_busy_off", 64'(busy), 64'd0);
        check_eq("t1_dup", 64'(dup_err), 64'd0);

        // Reverse completion: nothing leaves until core 0 is in.
        start_batch();
        check_eq("t2_done_cleared", 64'(batch_done), 64'd0);
        for (int i = 0; i < N; i++) push_exp(i, 32'hA + i);
        for (int i = N - 1; i > 0; i--) begin
            raise(i, 32'hA + i);
            @(posedge clk); #2 check_eq("t2_wait_core0", 64'(out_valid), 64'd0);
        end
        raise(0, 32'hA);
        drain(40, cyc);
        check_eq("t2_latency_b2b", 64'(cyc), 64'd6);
        check_eq("t2_batch_done", 64'(batch_done), 64'd1);
        drop_all();

        // All cores at once under five cycles of backpressure.
        out_ready = 1'b0;
        start_batch();
        for (int i = 0; i < N; i++) push_exp(i, 32'h3000 + i);
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) core_value[i*W +: W] = 32'h3000 + i;
        core_done = '1;
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #2;
            check_eq("t3_hold_valid", 64'(out_valid), 64'd1);
            check_eq("t3_hold_id", 64'(out_core_id), 64'd0);
            check_eq("t3_hold_data", 64'(out_data), 64'h3000);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        drain(40, cyc);
        check_eq("t3_four_beats", 64'(cyc), 64'd4);
        check_eq("t3_batch_done", 64'(batch_done), 64'd1);
        drop_all();

        // Core 2 reports twice; the first value must survive.
        start_batch();
        push_exp(0, 32'h40);
        push_exp(1, 32'h41);
        push_exp(2, 32'h22);
        push_exp(3, 32'h43);
        raise(2, 32'h22);
        drop(2);
        raise(2, 32'h99);
        drop(2);
        raise(0, 32'h40);
        raise(1, 32'h41);
        raise(3, 32'h43);
        drain(40, cyc);
        check_eq("t4_dup_err", 64'(dup_err), 64'd1);
        check_eq("t4_batch_done", 64'(batch_done), 64'd1);
        drop_all();

        // Reset in the middle of a batch throws the partial batch away.
        out_ready = 1'b0;
        start_batch();
        check_eq("t5_dup_cleared", 64'(dup_err), 64'd0);
        raise(0, 32'h55);
        raise(1, 32'h56);
        repeat (2) @(posedge clk);
        #2 check_eq("t5_pre_reset_valid", 64'(out_valid), 64'd1);
        #1 rst = 1'b0;
        @(posedge clk); #2 check_idle_outputs("t5_reset");
        rst       = 1'b1;
        core_done = '0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #2 check_eq("t5_no_stale_beat", 64'(out_valid), 64'd0);
        start_batch();
        for (int i = 0; i < N; i++) push_exp(i, 32'h500 + i);
        for (int i = 0; i < N; i++) raise(i, 32'h500 + i);
        drain(40, cyc);
        check_eq("t5_batch_done", 64'(batch_done), 64'd1);

        // Done levels left high must fall and rise again before recapture.
        out_ready = 1'b0;
        start_batch();
        for (int i = 0; i < N; i++) push_exp(i, 32'h70 + i);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
            check_eq("t6_no_held_capture", 64'(out_valid), 64'd0);
        end
        drop_all();
        raise(0, 32'h70);
        repeat (2) @(posedge clk);
        #2 check_eq("t6_core0_valid", 64'(out_valid), 64'd1);
        start_batch();
        #1;
        check_eq("t6_ignore_start_valid", 64'(out_valid), 64'd1);
        check_eq("t6_ignore_start_busy", 64'(busy), 64'd1);
        for (int i = 1; i < N; i++) raise(i, 32'h70 + i);
        @(posedge clk); #1 out_ready = 1'b1;
        drain(40, cyc);
        check_eq("t6_batch_done", 64'(batch_done), 64'd1);
        check_eq("t6_dup", 64'(dup_err), 64'd0);
        drop_all();

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 SHALL have parameter N, default 4, number of cnn_top cores whose results are gathered.
REQ-002 SHALL have parameter output_size, default 32, width of one core prediction.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset (rst=0 sampled at posedge resets).
REQ-005 SHALL have port batch_start  input  1  one-cycle request to open a new collection batch.
REQ-006 SHALL have port core_done  input  N  per-core done level from each core; bit i = core i.
REQ-007 SHALL have port core_value  input  N*output_size  flattened predictions; core i at bits [i*output_size +: output_size].
REQ-008 SHALL have port out_valid  output  1  result beat available.
REQ-009 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-010 SHALL have port out_data  output  output_size  captured prediction of the current beat.
REQ-011 SHALL have port out_core_id  output  max(1,$clog2(N))  index of the core owning out_data.
REQ-012 SHALL have port busy  output  1  high while in COLLECT.
REQ-013 SHALL have port batch_done  output  1  high in DONE state, all N results delivered.
REQ-014 SHALL have port dup_err  output  1  sticky: a core raised done twice in one batch.

Function
REQ-015 SHALL implement states IDLE, COLLECT, DONE; IDLE->COLLECT on batch_start; COLLECT->DONE on acceptance of the beat for core N-1; DONE->COLLECT on batch_start.
REQ-016 SHALL ignore batch_start while in COLLECT.
REQ-017 SHALL on entering COLLECT clear the captured-flag vector, the emit pointer (to 0), and dup_err.
REQ-018 SHALL register core_done every cycle (prev_done) in all states and detect capture events as core_done[i] & ~prev_done[i].
REQ-019 SHALL in COLLECT, on a capture event for core i with captured[i]=0, store core_value slice i into slot i and set captured[i].
REQ-020 SHALL in COLLECT, on a capture event for core i with captured[i]=1, keep slot i unchanged and set dup_err.
REQ-021 SHALL capture all simultaneous capture events in the same cycle; events outside COLLECT are discarded.
REQ-022 SHALL emit results strictly in core order 0..N-1 regardless of completion order.
REQ-023 SHALL assert out_valid registered, no earlier than the cycle after captured[ptr] becomes 1 (capture-to-valid latency exactly 1 cycle when the pointer already points at that core).
REQ-024 SHALL hold out_valid, out_data, out_core_id stable while out_valid=1 and out_ready=0.
REQ-025 SHALL on out_valid & out_ready advance ptr by 1; if the next slot is already captured, present it on the following cycle (back-to-back beats, one per cycle sustained).
REQ-026 SHALL drive out_valid=0 when the pointed slot is not yet captured.
REQ-027 SHALL assert batch_done the cycle after the final beat is accepted and hold it until the next accepted batch_start.
REQ-028 SHALL not require core_done to drop between capture and emission; a level held across batches is only recaptured after falling and rising again.

Reset
REQ-029 SHALL on rst=0 force state=IDLE, out_valid=0, out_data=0, out_core_id=0, busy=0, batch_done=0, dup_err=0, captured=0, ptr=0, prev_done=0.
REQ-030 SHALL on reset mid-batch discard all captured data with no further beats emitted until a new batch_start.

Verification
REQ-031 In-order: batch_start, cores 0..3 done one per cycle, out_ready=1 -> beats ids 0,1,2,3 with matching values, batch_done 1 cycle after beat 3.
REQ-032 Reverse completion: cores done 3,2,1,0 with values 0xD,0xC,0xB,0xA -> no out_valid until core 0 captured, then ids 0..3 back-to-back with 0xA,0xB,0xC,0xD.
REQ-033 Simultaneous + backpressure: all 4 done same cycle, out_ready=0 for 5 cycles -> out_valid=1, id 0 held stable 5 cycles, then 4 beats in 4 cycles.
REQ-034 Duplicate: core 2 done pulses twice (values 0x22 then 0x99) -> dup_err=1, beat for id 2 carries 0x22.
REQ-035 Reset mid-batch: rst=0 after 2 captures -> all outputs 0 next cycle; batch_start then new dones -> clean batch ids 0..3.
REQ-036 Held done: core_done left at 0xF after batch 1, new batch_start -> no captures until bits fall and rise; batch_start during COLLECT has no effect.
